otter_rfile_mp: RTL and testbench
=================================

// Module: otter_rfile_mp
// PURPOSE
//  Parametrised multi-port register file for the OTTER core family. It generalises the
//  2-read/1-write RV32 register file to N read and M write ports, with optional write-through
//  bypass and a per-register pending-write scoreboard for out-of-order writeback. It also has a
//  sequential bulk-clear engine. Sits between decode (reads, scoreboard set) and writeback.
// PARAMETERS
//  XLEN      32  data width per register
//  NREGS     32  register count (power of 2, >=2); AW = $clog2(NREGS) localparam
//  NUM_RD     2  read ports (>=1)
//  NUM_WR     1  write ports (>=1)
//  BYPASS     1  1: same-cycle write data forwarded to reads; 0: reads see pre-edge contents
//  ZERO_REG   1  1: register 0 hardwired to 0, writes/scoreboard-sets to it dropped
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             asynchronous active-low reset
//  r_addr       in   NUM_RD*AW     read addresses, port k = [k*AW +: AW]
//  r_data       out  NUM_RD*XLEN   read data, port k = [k*XLEN +: XLEN], combinational
//  r_busy       out  NUM_RD        scoreboard bit of r_addr[k] (pending write)
//  w_en         in   NUM_WR        per-port write enable
//  w_addr       in   NUM_WR*AW     write addresses
//  w_data       in   NUM_WR*XLEN   write data
//  sb_set_en    in   1             mark sb_set_addr as pending write
//  sb_set_addr  in   AW            register to mark busy
//  clr_start    in   1             start bulk clear (sampled only in IDLE)
//  clr_busy     out  1             1 while bulk clear in progress
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers=0, scoreboard=0, FSM=IDLE, clear counter=0, clr_busy=0.
//   Output r_data/r_busy then read 0 for every address. Reset mid-clear aborts the sweep.
//  Reads: combinational, zero latency. ZERO_REG=1 -> reg 0 always reads 0, r_busy=0.
//  Writes: on rising edge, for each port with w_en=1 the register at w_addr takes w_data.
//   Several ports hitting the same address in one cycle: the highest port index wins.
//   ZERO_REG=1 -> writes to address 0 ignored.
//  Bypass (BYPASS=1): if a read address matches an enabled write address in the same cycle,
//   r_data returns that w_data (highest-index matching port). Reg 0 is never bypassed
//   when ZERO_REG=1. BYPASS=0: reads return stored value; new data is visible the next cycle.
//   No bypass while FSM=CLEAR.
//  Scoreboard: one bit per register. Edge with sb_set_en=1 sets bit[sb_set_addr].
//   An enabled write on any port clears bit[w_addr]. Same-cycle set and write to one
//   address: set wins (bit=1, data still written). r_busy[k] reflects stored bits only
//   (not bypassed).
//  Clear FSM: IDLE --clr_start--> CLEAR (counter=0) --counter==NREGS-1--> IDLE.
//   In CLEAR: one register per cycle zeroed at index counter; counter += 1 per edge.
//   clr_busy=1 for exactly NREGS cycles. On the final edge all scoreboard bits clear.
//   During CLEAR: w_en, sb_set_en and clr_start are ignored, with no queuing.
//   Reads stay legal and return current contents, so partially cleared values are visible.
//  Widths: counter is AW bits and wraps only on CLEAR exit. No arithmetic on data.
// TESTING
//  1 Reset: hold rst_n=0, sweep all r_addr -> r_data=0, r_busy=0, clr_busy=0 (checks
//    clear the flops, not just initial values).
//  2 Write/read and bypass: write reg5=32'h12345678 with port1 reading 5 in the same cycle.
//    BYPASS=1 -> r_data=32'h12345678 before the edge. BYPASS=0 -> old value 0, then new
//    value after the edge.
//  3 Port conflict, NUM_WR=2: both ports write reg9 (port0=32'hAAAA0000,
//    port1=32'h5555FFFF) -> reg9=32'h5555FFFF. Write reg0=32'hDEADBEEF -> reads 0.
//  4 Scoreboard: set reg7 -> r_busy=1. Next cycle write reg7 -> r_busy=0.
//    Same-cycle set and write reg7=32'hCAFEBABE -> r_busy=1, data=32'hCAFEBABE.
//  5 Bulk clear: fill regs 1..31 with 32'h1000_0000+i, pulse clr_start -> clr_busy high
//    32 cycles. A write of reg3 mid-clear is dropped. Afterwards all regs=0, all r_busy=0.
//  6 Reset mid-clear: assert rst_n=0 at counter=10 -> immediate IDLE, clr_busy=0, all regs 0.
//    Next clr_start runs a full 32-cycle sweep.

Source files
------------

// File: rtl/otter_rfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : otter_rfile_mp
// Brief    : N-read / M-write register file with write-through bypass,
//            pending-write scoreboard and a sequential bulk-clear engine.
// Revision : 1.0
// ============================================================================
module otter_rfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   r_addr,
  output logic [NUM_RD*XLEN-1:0] r_data,
  output logic [NUM_RD-1:0]      r_busy,
  input  logic [NUM_WR-1:0]      w_en,
  input  logic [NUM_WR*AW-1:0]   w_addr,
  input  logic [NUM_WR*XLEN-1:0] w_data,
  input  logic                   sb_set_en,
  input  logic [AW-1:0]          sb_set_addr,
  input  logic                   clr_start,
  output logic                   clr_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [AW-1:0]     clr_cnt;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_start) state_d = S_CLEAR;
      S_CLEAR: if (clr_cnt == LAST_IDX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign clr_busy = (state_q == S_CLEAR);

  // Later loop iterations override earlier ones, so the highest write port
  // wins on address conflicts and a scoreboard set beats a write-side clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      sb      <= '0;
      clr_cnt <= '0;
    end else if (state_q == S_CLEAR) begin
      regs[clr_cnt] <= '0;
      clr_cnt       <= clr_cnt + 1'b1;
      if (clr_cnt == LAST_IDX) begin
        sb <= '0;
      end
    end else begin
      clr_cnt <= '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_en[p]) begin
          sb[w_addr[p*AW +: AW]] <= 1'b0;
          if (!(ZERO_REG != 0 && w_addr[p*AW +: AW] == '0)) begin
            regs[w_addr[p*AW +: AW]] <= w_data[p*XLEN +: XLEN];
          end
        end
      end
      if (sb_set_en && !(ZERO_REG != 0 && sb_set_addr == '0)) begin
        sb[sb_set_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] word;
    ra     = '0;
    word   = '0;
    r_data = '0;
    r_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra   = r_addr[k*AW +: AW];
      word = regs[ra];
      if (BYPASS != 0 && state_q == S_IDLE) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (w_en[p] && w_addr[p*AW +: AW] == ra) begin
            word = w_data[p*XLEN +: XLEN];
          end
        end
      end
      if (ZERO_REG != 0 && ra == '0) begin
        word = '0;
      end
      r_data[k*XLEN +: XLEN] = word;
      r_busy[k]              = sb[ra] && !(ZERO_REG != 0 && ra == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_rfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_rfile_mp
// Brief    : Self-checking bench for otter_rfile_mp (2 read / 2 write ports).
// Revision : 1.0
// ============================================================================
module tb_otter_rfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_RD*AW-1:0]   r_addr;
  logic [NUM_RD*XLEN-1:0] r_data;
  logic [NUM_RD-1:0]      r_busy;
  logic [NUM_WR-1:0]      w_en;
  logic [NUM_WR*AW-1:0]   w_addr;
  logic [NUM_WR*XLEN-1:0] w_data;
  logic                   sb_set_en;
  logic [AW-1:0]          sb_set_addr;
  logic                   clr_start;
  logic                   clr_busy;

  int               total = 0;
  int               bad   = 0;
  logic [XLEN-1:0]  mdl [NREGS];
  logic             msb [NREGS];
  logic [XLEN-1:0]  exp_q [$];
  logic [XLEN-1:0]  got;
  logic [XLEN-1:0]  want;

  otter_rfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .clr_start(clr_start), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    w_en        = '0;
    w_addr      = '0;
    w_data      = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
    clr_start   = 1'b0;
  endtask

  task automatic model_zero();
    for (int i = 0; i < NREGS; i++) begin
      mdl[i] = '0;
      msb[i] = 1'b0;
    end
  endtask

  task automatic drive_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    w_en[p]               = 1'b1;
    w_addr[p*AW +: AW]     = a;
    w_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    r_addr = '0;
    rst_n  = 1'b1;
    model_zero();
    #2 rst_n = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      @(negedge clk);
      r_addr = {AW'(a), AW'(a)};
      exp_q.push_back(mdl[a]);
      exp_q.push_back(mdl[a]);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        got = r_data[k*XLEN +: XLEN]; want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL reset_data a=%0d k=%0d got=%h want=%h", a, k, got, want); end
        total++;
        if (r_busy[k] !== msb[a]) begin bad++; $display("FAIL reset_busy a=%0d k=%0d got=%b want=%b", a, k, r_busy[k], msb[a]); end
      end
      total++;
      if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_clr_busy got=%b want=0", clr_busy); end
    end
    // Put real state into the flops, then reset again asynchronously.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_wr(0, 5'd4, 32'h0BAD_F00D);
    sb_set_en = 1'b1; sb_set_addr = 5'd6;
    @(negedge clk);
    idle_inputs();
    r_addr = {5'd6, 5'd4};
    exp_q.push_back(32'h0BAD_F00D);
    #1;
    got = r_data[0 +: XLEN]; want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL pre_reset_data got=%h want=%h", got, want); end
    total++;
    if (r_busy[1] !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b want=1", r_busy[1]); end
    rst_n = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    got = r_data[0 +: XLEN]; want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL async_reset_data got=%h want=%h", got, want); end
    total++;
    if (r_busy[1] !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%b want=0", r_busy[1]); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    drive_wr(0, 5'd5, 32'h1234_5678);
    r_addr = {5'd5, 5'd0};
    exp_q.push_back(32'h1234_5678);
    #1;
    got = r_data[XLEN +: XLEN]; want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL bypass_rd got=%h want=%h", got, want); end
    total++;
    if (r_busy[1] !== 1'b0) begin bad++; $display("FAIL bypass_busy got=%b want=0", r_busy[1]); end
    mdl[5] = 32'h1234_5678;
    // Port 1 writes reg6 while port 0 reads it and port 1 reads stored reg5.
    @(negedge clk);
    idle_inputs();
    drive_wr(1, 5'd6, 32'h0F0F_1234);
    r_addr = {5'd5, 5'd6};
    exp_q.push_back(32'h0F0F_1234);
    exp_q.push_back(mdl[5]);
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_data[k*XLEN +: XLEN]; want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL bypass_mix k=%0d got=%h want=%h", k, got, want); end
    end
    mdl[6] = 32'h0F0F_1234;
    @(negedge clk);
    idle_inputs();
    r_addr = {5'd6, 5'd5};
    exp_q.push_back(mdl[5]);
    exp_q.push_back(mdl[6]);
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_data[k*XLEN +: XLEN]; want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL stored_rd k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    drive_wr(0, 5'd9, 32'hAAAA_0000);
    drive_wr(1, 5'd9, 32'h5555_FFFF);
    r_addr = {5'd9, 5'd9};
    exp_q.push_back(32'h5555_FFFF);
    #1;
    got = r_data[0 +: XLEN]; want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL conflict_bypass got=%h want=%h", got, want); end
    mdl[9] = 32'h5555_FFFF;
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(mdl[9]);
    #1;
    got = r_data[0 +: XLEN]; want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL conflict_stored got=%h want=%h", got, want); end
    @(negedge clk);
    drive_wr(0, 5'd0, 32'hDEAD_BEEF);
    r_addr = {5'd0, 5'd0};
    exp_q.push_back(32'h0);
    #1;
    got = r_data[0 +: XLEN]; want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL zero_bypass got=%h want=%h", got, want); end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'h0);
    #1;
    got = r_data[0 +: XLEN]; want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL zero_stored got=%h want=%h", got, want); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    r_addr = {5'd7, 5'd7};
    #1;
    total++;
    if (r_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_not_bypassed got=%b want=0", r_busy[0]); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (r_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_set got=%b want=1", r_busy[0]); end
    drive_wr(0, 5'd7, 32'h0000_0077);
    #1;
    total++;
    if (r_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_before_wr got=%b want=1", r_busy[0]); end
    @(negedge clk);
    idle_inputs();
    mdl[7] = 32'h0000_0077;
    #1;
    total++;
    if (r_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b want=0", r_busy[0]); end
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    drive_wr(1, 5'd7, 32'hCAFE_BABE);
    @(negedge clk);
    idle_inputs();
    mdl[7] = 32'hCAFE_BABE; msb[7] = 1'b1;
    exp_q.push_back(mdl[7]);
    #1;
    got = r_data[0 +: XLEN]; want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL sb_race_data got=%h want=%h", got, want); end
    total++;
    if (r_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_race_busy got=%b want=1", r_busy[0]); end
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    @(negedge clk);
    idle_inputs();
    r_addr = {5'd0, 5'd7};
    #1;
    total++;
    if (r_busy[1] !== 1'b0) begin bad++; $display("FAIL sb_zero got=%b want=0", r_busy[1]); end
  endtask

  task automatic fill_regs();
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      idle_inputs();
      drive_wr(0, AW'(i), 32'h1000_0000 + i);
      mdl[i] = 32'h1000_0000 + i;
      msb[i] = 1'b0;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_bulk_clear();
    int n;
    fill_regs();
    sb_set_en = 1'b1; sb_set_addr = 5'd12;
    @(negedge clk);
    idle_inputs();
    msb[12] = 1'b1;
    r_addr = {5'd12, 5'd12};
    #1;
    total++;
    if (r_busy[0] !== 1'b1) begin bad++; $display("FAIL pre_clr_busy got=%b want=1", r_busy[0]); end
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      if (n == 10) begin
        drive_wr(0, 5'd3, 32'h3333_3333);
        r_addr = {5'd20, 5'd3};
        exp_q.push_back(32'h0);
        exp_q.push_back(mdl[20]);
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
          got = r_data[k*XLEN +: XLEN]; want = exp_q.pop_front();
          total++;
          if (got !== want) begin bad++; $display("FAIL mid_clear_rd k=%0d got=%h want=%h", k, got, want); end
        end
      end else if (n == 20) begin
        clr_start = 1'b1;
        sb_set_en = 1'b1; sb_set_addr = 5'd25;
      end else begin
        idle_inputs();
      end
      n++;
      @(negedge clk);
    end
    idle_inputs();
    total++;
    if (n !== 32) begin bad++; $display("FAIL clr_cycles got=%0d want=32", n); end
    model_zero();
    for (int a = 0; a < NREGS; a++) begin
      @(negedge clk);
      r_addr = {AW'(a), AW'(a)};
      exp_q.push_back(mdl[a]);
      #1;
      got = r_data[XLEN +: XLEN]; want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL post_clr_data a=%0d got=%h want=%h", a, got, want); end
      total++;
      if (r_busy[1] !== msb[a]) begin bad++; $display("FAIL post_clr_busy a=%0d got=%b want=%b", a, r_busy[1], msb[a]); end
      total++;
      if (clr_busy !== 1'b0) begin bad++; $display("FAIL post_clr_state got=%b want=0", clr_busy); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    fill_regs();
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    for (int j = 0; j < 10; j++) @(negedge clk);
    r_addr = {5'd15, 5'd9};
    exp_q.push_back(32'h0);
    exp_q.push_back(mdl[15]);
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_data[k*XLEN +: XLEN]; want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL partial_clr k=%0d got=%h want=%h", k, got, want); end
    end
    total++;
    if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_running got=%b want=1", clr_busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if (clr_busy !== 1'b0) begin bad++; $display("FAIL abort_clr_busy got=%b want=0", clr_busy); end
    model_zero();
    for (int a = 0; a < NREGS; a++) begin
      @(negedge clk);
      r_addr = {AW'(a), AW'(a)};
      exp_q.push_back(mdl[a]);
      #1;
      got = r_data[0 +: XLEN]; want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL abort_data a=%0d got=%h want=%h", a, got, want); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== 32) begin bad++; $display("FAIL reclr_cycles got=%0d want=32", n); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_conflict();
    test_scoreboard();
    test_bulk_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
